alu_cmd_master: RTL and testbench

ALU_CMD_MASTER -- requirements
Module: alu_cmd_master

---
 rtl/alu_cmd_master.sv | 116 +++++++++++
 tb/tb_alu_cmd_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_master.sv
// Host-side ALU command master: packs host commands into FIFO words and tracks the
// in-flight opcodes so each returning result is tagged with the opcode that produced it.
module alu_cmd_master #(
  parameter int unsigned MAX_OUT = 8
) (
  input  logic                      p_clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_op,
  input  logic [13:0]               cmd_a,
  input  logic [13:0]               cmd_b,
  output logic [31:0]               data_out,
  output logic                      wr_req,
  input  logic                      full,
  input  logic [27:0]               data_in,
  input  logic                      valid,
  output logic [27:0]               res_out,
  output logic [2:0]                res_op,
  output logic                      res_valid,
  input  logic                      flush,
  output logic                      flush_done,
  output logic [$clog2(MAX_OUT):0]  outstanding,
  output logic                      orphan_err
);

  localparam int unsigned PtrW = $clog2(MAX_OUT);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e          state_q;
  logic [2:0]      op_q [MAX_OUT];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] outstanding_d;
  logic            accept;
  logic            pop;
  logic            orphan;

  // A flush in the same cycle wins over a pending command, so it also drops ready.
  assign cmd_ready = rst && (state_q != StDrain) && !flush && !full &&
                     (outstanding < CntW'(MAX_OUT));
  assign accept    = cmd_valid && cmd_ready;
  assign pop       = valid && (outstanding != '0);
  assign orphan    = valid && (outstanding == '0);

  always_comb begin
    outstanding_d = outstanding;
    unique case ({accept, pop})
      2'b10:   outstanding_d = outstanding + CntW'(1);
      2'b01:   outstanding_d = outstanding - CntW'(1);
      default: outstanding_d = outstanding;
    endcase
  end

  always_ff @(posedge p_clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      data_out    <= '0;
      wr_req      <= 1'b0;
      res_out     <= '0;
      res_op      <= '0;
      res_valid   <= 1'b0;
      flush_done  <= 1'b0;
      outstanding <= '0;
      orphan_err  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      wr_req <= accept;
      if (accept) begin
        data_out          <= {cmd_op, cmd_a, cmd_b, 1'b0};
        op_q[wr_ptr_q]    <= cmd_op;
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end

      res_valid <= pop;
      if (pop) begin
        res_out  <= data_in;
        res_op   <= op_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end

      outstanding <= outstanding_d;
      if (orphan) orphan_err <= 1'b1;

      flush_done <= 1'b0;
      unique case (state_q)
        StIdle, StBusy: begin
          if (flush) begin
            // Nothing left in flight: complete the drain immediately.
            if (outstanding_d == '0) begin
              state_q    <= StIdle;
              flush_done <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end else if (accept) begin
            state_q <= StBusy;
          end else if (state_q == StBusy && outstanding_d == '0) begin
            state_q <= StIdle;
          end
        end
        StDrain: begin
          if (outstanding_d == '0) begin
            state_q    <= StIdle;
            flush_done <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_master.sv
// Directed bench for alu_cmd_master: reset, command packing, burst, tagging,
// backpressure, flush and orphan-result behaviour.
module tb_alu_cmd_master;

  localparam int unsigned MAX_OUT = 8;

  logic        p_clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [13:0] cmd_a;
  logic [13:0] cmd_b;
  logic [31:0] data_out;
  logic        wr_req;
  logic        full;
  logic [27:0] data_in;
  logic        valid;
  logic [27:0] res_out;
  logic [2:0]  res_op;
  logic        res_valid;
  logic        flush;
  logic        flush_done;
  logic [3:0]  outstanding;
  logic        orphan_err;

  int checks   = 0;
  int failures = 0;

  alu_cmd_master #(.MAX_OUT(MAX_OUT)) dut (
    .p_clk       (p_clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .data_out    (data_out),
    .wr_req      (wr_req),
    .full        (full),
    .data_in     (data_in),
    .valid       (valid),
    .res_out     (res_out),
    .res_op      (res_op),
    .res_valid   (res_valid),
    .flush       (flush),
    .flush_done  (flush_done),
    .outstanding (outstanding),
    .orphan_err  (orphan_err)
  );

  always #5 p_clk = ~p_clk;

  task automatic tick();
    @(posedge p_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [13:0] a, input logic [13:0] b);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
  endtask

  logic [27:0] burst_data [8];

  initial begin
    burst_data = '{28'd16, 28'd4, 28'd1, 28'd13, 28'd45, 28'd0, 28'd1, 28'd12};
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    full = 1'b0; data_in = '0; valid = 1'b0; flush = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_orphan", 32'(orphan_err), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_res_out", 32'(res_out), 32'd0);
    rst = 1'b1;
    #1 chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // ADD command
    send(3'd0, 14'd8, 14'd8);
    tick();
    cmd_valid = 1'b0;
    chk("add_word", data_out, 32'h00040010);
    chk("add_wr_req", 32'(wr_req), 32'd1);
    chk("add_outstanding", 32'(outstanding), 32'd1);
    valid = 1'b1; data_in = 28'd16;
    tick();
    valid = 1'b0;
    chk("add_wr_req_drop", 32'(wr_req), 32'd0);
    chk("add_word_hold", data_out, 32'h00040010);
    chk("add_res_valid", 32'(res_valid), 32'd1);
    chk("add_res_out", 32'(res_out), 32'd16);
    chk("add_res_op", 32'(res_op), 32'd0);
    chk("add_outstanding_0", 32'(outstanding), 32'd0);
    tick();
    chk("add_res_valid_drop", 32'(res_valid), 32'd0);

    // Burst of eight, fills the tag queue
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 14'd9, 14'd5);
      tick();
      chk("burst_wr_req", 32'(wr_req), 32'd1);
      chk("burst_outstanding", 32'(outstanding), 32'(i + 1));
      if (i == 1) chk("burst_sub_word", data_out, 32'h2004800A);
    end
    #1 chk("burst_full_ready", 32'(cmd_ready), 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("burst_no_extra_wr", 32'(wr_req), 32'd0);
    chk("burst_outstanding_8", 32'(outstanding), 32'd8);
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; data_in = burst_data[i];
      tick();
      chk("burst_res_valid", 32'(res_valid), 32'd1);
      chk("burst_res_op", 32'(res_op), 32'(i));
      chk("burst_res_out", 32'(res_out), 32'(burst_data[i]));
    end
    valid = 1'b0;
    tick();
    chk("burst_res_valid_drop", 32'(res_valid), 32'd0);
    chk("burst_outstanding_0", 32'(outstanding), 32'd0);

    // Simultaneous accept and result with three in flight
    send(3'd5, 14'd1, 14'd2); tick();
    send(3'd6, 14'd1, 14'd2); tick();
    send(3'd7, 14'd1, 14'd2); tick();
    chk("sim_pre_outstanding", 32'(outstanding), 32'd3);
    send(3'd2, 14'd1, 14'd2);
    valid = 1'b1; data_in = 28'd100;
    tick();
    cmd_valid = 1'b0;
    chk("sim_outstanding", 32'(outstanding), 32'd3);
    chk("sim_res_op", 32'(res_op), 32'd5);
    chk("sim_res_out", 32'(res_out), 32'd100);
    chk("sim_wr_req", 32'(wr_req), 32'd1);
    data_in = 28'd200; tick(); chk("sim_res_op_2", 32'(res_op), 32'd6);
    data_in = 28'd300; tick(); chk("sim_res_op_3", 32'(res_op), 32'd7);
    data_in = 28'd400; tick(); chk("sim_res_op_4", 32'(res_op), 32'd2);
    chk("sim_res_out_4", 32'(res_out), 32'd400);
    valid = 1'b0;
    chk("sim_outstanding_0", 32'(outstanding), 32'd0);

    // Backpressure
    full = 1'b1;
    send(3'd3, 14'd4, 14'd6);
    #1 chk("bp_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    chk("bp_no_wr", 32'(wr_req), 32'd0);
    chk("bp_outstanding", 32'(outstanding), 32'd0);
    full = 1'b0;
    #1 chk("bp_ready_high", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("bp_wr", 32'(wr_req), 32'd1);
    chk("bp_word", data_out, 32'h6002000C);
    chk("bp_outstanding_1", 32'(outstanding), 32'd1);

    // Flush with two in flight; a command offered alongside must be refused
    send(3'd4, 14'd0, 14'd0);
    tick();
    chk("fl_word", data_out, 32'h80000000);
    chk("fl_outstanding_2", 32'(outstanding), 32'd2);
    flush = 1'b1;
    #1 chk("fl_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_no_accept", 32'(wr_req), 32'd0);
    chk("fl_outstanding_hold", 32'(outstanding), 32'd2);
    chk("drain_ready_low", 32'(cmd_ready), 32'd0);
    valid = 1'b1; data_in = 28'd7;
    tick();
    chk("drain_res_op_1", 32'(res_op), 32'd3);
    chk("drain_done_early", 32'(flush_done), 32'd0);
    data_in = 28'd8;
    tick();
    valid = 1'b0; cmd_valid = 1'b0;
    chk("drain_res_op_2", 32'(res_op), 32'd4);
    chk("drain_res_out_2", 32'(res_out), 32'd8);
    chk("drain_done", 32'(flush_done), 32'd1);
    chk("drain_outstanding_0", 32'(outstanding), 32'd0);
    #1 chk("drain_idle_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("drain_done_pulse", 32'(flush_done), 32'd0);

    // Flush while idle and empty
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("idle_flush_done", 32'(flush_done), 32'd1);
    tick();
    chk("idle_flush_pulse", 32'(flush_done), 32'd0);

    // Orphan result
    valid = 1'b1; data_in = 28'd5;
    tick();
    valid = 1'b0;
    chk("orph_no_res", 32'(res_valid), 32'd0);
    chk("orph_err", 32'(orphan_err), 32'd1);
    chk("orph_outstanding", 32'(outstanding), 32'd0);
    tick();
    chk("orph_sticky", 32'(orphan_err), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("orph_cleared", 32'(orphan_err), 32'd0);

    // Reset mid-operation discards in-flight tags
    send(3'd1, 14'd2, 14'd3); tick();
    send(3'd2, 14'd2, 14'd3); tick();
    cmd_valid = 1'b0;
    chk("mid_outstanding", 32'(outstanding), 32'd2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_outstanding", 32'(outstanding), 32'd0);
    chk("mid_rst_word", data_out, 32'h0);
    valid = 1'b1; data_in = 28'd9;
    tick();
    valid = 1'b0;
    chk("mid_late_no_res", 32'(res_valid), 32'd0);
    chk("mid_late_orphan", 32'(orphan_err), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
